regfile_scoreboard: RTL



---
 rtl/regfile_scoreboard_if.sv | 45 ++++
 rtl/regfile_scoreboard.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard_if.sv
// regfile_scoreboard_if
//   Bundles the decode-side read/issue signals and the writeback signals of
//   the register file scoreboard into one port.
//   master : decode/writeback side (drives addresses, strobes, write data)
//   slave  : register file (returns read data, rd_valid, stall, pend_cnt)
//   Optional macro REGFILE_BYTE_WRITE_EN adds wr_be (DATA_W/8 byte enables).
interface regfile_scoreboard_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr1;
  logic [ADDR_W-1:0] rd_addr2;
  logic [DATA_W-1:0] rd_data1;
  logic [DATA_W-1:0] rd_data2;
  logic              rd_valid;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              pend_set;
  logic [ADDR_W-1:0] pend_addr;
  logic              stall;
  logic [ADDR_W:0]   pend_cnt;
`ifdef REGFILE_BYTE_WRITE_EN
  logic [DATA_W/8-1:0] wr_be;
`endif

  modport master (
`ifdef REGFILE_BYTE_WRITE_EN
    output wr_be,
`endif
    output rd_en, rd_addr1, rd_addr2, wr_en, wr_addr, wr_data,
    output pend_set, pend_addr,
    input  rd_data1, rd_data2, rd_valid, stall, pend_cnt
  );

  modport slave (
`ifdef REGFILE_BYTE_WRITE_EN
    input  wr_be,
`endif
    input  rd_en, rd_addr1, rd_addr2, wr_en, wr_addr, wr_data,
    input  pend_set, pend_addr,
    output rd_data1, rd_data2, rd_valid, stall, pend_cnt
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
//   Parametrised register file with two registered read ports, same-cycle
//   write-to-read forwarding, optional hardwired zero register and a
//   pending-write scoreboard that raises a combinational stall on RAW hazards.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset (clears registers, pending bits,
//          read outputs and the pending counter)
//   bus  - regfile_scoreboard_if.slave: read port (rd_en, rd_addr1/2,
//          rd_data1/2, rd_valid), writeback (wr_en, wr_addr, wr_data),
//          issue (pend_set, pend_addr), stall and pend_cnt.
// Optional macro REGFILE_BYTE_WRITE_EN: enables per-byte write via bus.wr_be;
//   forwarding merges bytes the same way. Without it every write is full-word.
module regfile_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int DEPTH    = 32,
  parameter int ZERO_REG = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_scoreboard_if.slave  bus
);
  localparam int NB = DATA_W / 8;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [NB-1:0]     be;
  logic              wr_ok;
  logic              set_ok;
  logic [DEPTH-1:0]  pending_reg;
  logic [DEPTH-1:0]  pending_next;
  logic [DEPTH-1:0]  set_vec;
  logic [DEPTH-1:0]  clr_vec;
  logic [DEPTH-1:0]  wr_hit;
  logic [DEPTH-1:0]  hit1;
  logic [DEPTH-1:0]  hit2;
  logic              cnt_inc;
  logic              cnt_dec;
  logic [ADDR_W:0]   cnt_reg;
  logic [ADDR_W:0]   cnt_next;
  logic [DATA_W-1:0] rd_data1_reg;
  logic [DATA_W-1:0] rd_data2_reg;
  logic [DATA_W-1:0] val1;
  logic [DATA_W-1:0] val2;
  logic              rd_valid_reg;

  // An address is backed by real storage when it is inside DEPTH and is not
  // the hardwired zero register.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < DEPTH_L) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  // Read value of address a given its stored word: zero for unbacked
  // addresses, otherwise stored word with any same-cycle write bytes merged in.
  function automatic logic [DATA_W-1:0] read_value(
    input logic [ADDR_W-1:0] a,
    input logic [DATA_W-1:0] stored
  );
    logic [DATA_W-1:0] v;
    v = '0;
    if (addr_ok(a)) begin
      v = stored;
      if (bus.wr_en && (bus.wr_addr == a)) begin
        for (int b = 0; b < NB; b++) begin
          if (be[b]) v[b*8 +: 8] = bus.wr_data[b*8 +: 8];
        end
      end
    end
    return v;
  endfunction

`ifdef REGFILE_BYTE_WRITE_EN
  assign be = bus.wr_be;
`else
  assign be = '1;
`endif

  assign wr_ok  = bus.wr_en && addr_ok(bus.wr_addr);
  assign set_ok = bus.pend_set && addr_ok(bus.pend_addr);

  // Per-register one-hot decodes of every address in play this cycle.
  // wr_hit uses the raw strobe: an unbacked register is never pending anyway.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_dec
      localparam logic [ADDR_W-1:0] IDX = ADDR_W'(gi);
      assign wr_hit[gi]  = bus.wr_en && (bus.wr_addr == IDX);
      assign clr_vec[gi] = wr_ok && (bus.wr_addr == IDX);
      assign set_vec[gi] = set_ok && (bus.pend_addr == IDX);
      assign hit1[gi]    = (bus.rd_addr1 == IDX);
      assign hit2[gi]    = (bus.rd_addr2 == IDX);
    end
  endgenerate

  // Storage. Byte enables are all ones in the full-word build, and the pending
  // clear (clr_vec) fires even when no byte is enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        for (int b = 0; b < NB; b++) begin
          if (clr_vec[i] && be[b]) mem[i][b*8 +: 8] <= bus.wr_data[b*8 +: 8];
        end
      end
    end
  end

  always_comb begin
    val1 = read_value(bus.rd_addr1, mem[bus.rd_addr1]);
    val2 = read_value(bus.rd_addr2, mem[bus.rd_addr2]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data1_reg <= '0;
      rd_data2_reg <= '0;
      rd_valid_reg <= 1'b0;
    end else begin
      rd_valid_reg <= bus.rd_en;
      if (bus.rd_en) begin
        rd_data1_reg <= val1;
        rd_data2_reg <= val2;
      end
    end
  end

  // Scoreboard. A set overrides a clear on the same register because a newer
  // producer has been issued. The counter tracks transitions, so it only moves
  // on a real 0->1 or 1->0 change of some pending bit.
  assign pending_next = (pending_reg & ~clr_vec) | set_vec;
  assign cnt_inc      = |(set_vec & ~pending_reg);
  assign cnt_dec      = |(clr_vec & pending_reg & ~set_vec);
  assign cnt_next     = cnt_reg + {{ADDR_W{1'b0}}, cnt_inc} - {{ADDR_W{1'b0}}, cnt_dec};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_reg <= '0;
      cnt_reg     <= '0;
    end else begin
      pending_reg <= pending_next;
      cnt_reg     <= cnt_next;
    end
  end

  // A writeback landing this cycle resolves the hazard through forwarding;
  // a pend_set this cycle is not yet visible in pending_reg.
  assign bus.stall = bus.rd_en &&
                     ((|(hit1 & pending_reg & ~wr_hit)) ||
                      (|(hit2 & pending_reg & ~wr_hit)));

  assign bus.rd_data1 = rd_data1_reg;
  assign bus.rd_data2 = rd_data2_reg;
  assign bus.rd_valid = rd_valid_reg;
  assign bus.pend_cnt = cnt_reg;
endmodule
